// File: rtl/td4x_pkg.sv
// td4x_pkg: shared definitions for the td4x CPU core.
//   - Opcode values for the 4-bit op field at the top of each instruction word.
//   - FSM state encoding (fetch / execute / halt).
//   - Adder source-select and destination-select encodings used by the decoder.
package td4x_pkg;

  localparam logic [3:0] OP_ADD_A    = 4'b0000;
  localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
  localparam logic [3:0] OP_IN_A     = 4'b0010;
  localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
  localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
  localparam logic [3:0] OP_ADD_B    = 4'b0101;
  localparam logic [3:0] OP_IN_B     = 4'b0110;
  localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
  localparam logic [3:0] OP_OUT_B    = 4'b1001;
  localparam logic [3:0] OP_OUT_IM   = 4'b1011;
  localparam logic [3:0] OP_HLT      = 4'b1101;
  localparam logic [3:0] OP_JNC      = 4'b1110;
  localparam logic [3:0] OP_JMP      = 4'b1111;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SRC_A    = 2'd0,
    SRC_B    = 2'd1,
    SRC_IN   = 2'd2,
    SRC_ZERO = 2'd3
  } src_t;

  // Where the adder result is written; DST_NONE marks non-arithmetic ops.
  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_A    = 2'd1,
    DST_B    = 2'd2,
    DST_OUT  = 2'd3
  } dst_t;

endpackage

// File: rtl/td4x_alu.sv
// td4x_alu: combinational DATA_W-bit adder shared by every data-moving op.
//   src       in  DATA_W  selected source operand (A, B, input port or zero)
//   im        in  DATA_W  immediate field of the instruction
//   sum       out DATA_W  low DATA_W bits of src + im
//   carry_out out 1       bit DATA_W of src + im
module td4x_alu #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] src,
  input  logic [DATA_W-1:0] im,
  output logic [DATA_W-1:0] sum,
  output logic              carry_out
);

  logic [DATA_W:0] full_sum;

  assign full_sum  = {1'b0, src} + {1'b0, im};
  assign sum       = full_sum[DATA_W-1:0];
  assign carry_out = full_sum[DATA_W];

endmodule

// File: rtl/td4x_core.sv
// td4x_core: parametrised TD4-compatible CPU core.
//   clk         in  1        system clock, all state on the rising edge
//   reset       in  1        asynchronous active-low reset
//   imem_addr   out ADDR_W   instruction fetch address (the registered PC)
//   imem_req    out 1        fetch request, high throughout S_FETCH
//   imem_ack    in  1        instruction valid, sampled with imem_data while requesting
//   imem_data   in  INSTR_W  instruction word {op[3:0], im[DATA_W-1:0]}
//   inp         in  DATA_W   input port, read by IN A / IN B
//   outp        out DATA_W   output port register
//   out_strobe  out 1        one-cycle pulse in the cycle after an OUT executes
//   halted      out 1        high while in S_HALT
//   carry       out 1        current carry flag
module td4x_core
  import td4x_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 4 + DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic [DATA_W-1:0]  inp,
  output logic [DATA_W-1:0]  outp,
  output logic               out_strobe,
  output logic               halted,
  output logic               carry
);

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   pc;
  logic [INSTR_W-1:0]  ir;
  logic [DATA_W-1:0]   reg_a;
  logic [DATA_W-1:0]   reg_b;
  logic [DATA_W-1:0]   outp_q;
  logic                carry_q;
  logic                out_strobe_q;

  logic [3:0]          op;
  logic [DATA_W-1:0]   im;
  src_t                src_sel;
  dst_t                dst_sel;
  logic                is_jmp;
  logic                is_jnc;
  logic                is_hlt;

  logic [DATA_W-1:0]   alu_src;
  logic [DATA_W-1:0]   alu_sum;
  logic                alu_carry;

  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   jump_target;
  logic [ADDR_W-1:0]   pc_next;

  assign op = ir[INSTR_W-1 -: 4];
  assign im = ir[DATA_W-1:0];

  // Decode: only the op field steers control, so an unused immediate
  // can never leak into pc, carry or the register file.
  always_comb begin
    src_sel = SRC_ZERO;
    dst_sel = DST_NONE;
    is_jmp  = 1'b0;
    is_jnc  = 1'b0;
    is_hlt  = 1'b0;
    case (op)
      OP_ADD_A:    begin src_sel = SRC_A;    dst_sel = DST_A;   end
      OP_ADD_B:    begin src_sel = SRC_B;    dst_sel = DST_B;   end
      OP_MOV_A_IM: begin src_sel = SRC_ZERO; dst_sel = DST_A;   end
      OP_MOV_B_IM: begin src_sel = SRC_ZERO; dst_sel = DST_B;   end
      OP_MOV_A_B:  begin src_sel = SRC_B;    dst_sel = DST_A;   end
      OP_MOV_B_A:  begin src_sel = SRC_A;    dst_sel = DST_B;   end
      OP_IN_A:     begin src_sel = SRC_IN;   dst_sel = DST_A;   end
      OP_IN_B:     begin src_sel = SRC_IN;   dst_sel = DST_B;   end
      OP_OUT_B:    begin src_sel = SRC_B;    dst_sel = DST_OUT; end
      OP_OUT_IM:   begin src_sel = SRC_ZERO; dst_sel = DST_OUT; end
      OP_JMP:      is_jmp = 1'b1;
      OP_JNC:      is_jnc = 1'b1;
      OP_HLT:      is_hlt = 1'b1;
      default:     ;
    endcase
  end

  always_comb begin
    case (src_sel)
      SRC_A:   alu_src = reg_a;
      SRC_B:   alu_src = reg_b;
      SRC_IN:  alu_src = inp;
      default: alu_src = '0;
    endcase
  end

  td4x_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .src       (alu_src),
    .im        (im),
    .sum       (alu_sum),
    .carry_out (alu_carry)
  );

  // pc arithmetic wraps naturally at ADDR_W bits.
  assign pc_inc      = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign jump_target = im[ADDR_W-1:0];

  // JNC looks at carry_q, i.e. the flag left by the previous instruction.
  always_comb begin
    if (is_jmp)
      pc_next = jump_target;
    else if (is_jnc)
      pc_next = carry_q ? pc_inc : jump_target;
    else
      pc_next = pc_inc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= S_FETCH;
    else
      state_q <= state_d;
  end

  // imem_req is gated by reset so the request drops the instant reset
  // asserts, even though state_q already sits at S_FETCH.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = reset;
        if (imem_ack)
          state_d = S_EXEC;
      end
      S_EXEC:  state_d = is_hlt ? S_HALT : S_FETCH;
      S_HALT:  halted  = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  // Control state: pc, carry flag and the output strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc           <= '0;
      carry_q      <= 1'b0;
      out_strobe_q <= 1'b0;
    end else begin
      out_strobe_q <= (state_q == S_EXEC) && (dst_sel == DST_OUT);
      if ((state_q == S_EXEC) && !is_hlt) begin
        pc      <= pc_next;
        // Adder ops publish their carry; jumps and NOPs clear it.
        carry_q <= (dst_sel != DST_NONE) ? alu_carry : 1'b0;
      end
    end
  end

  // Data state: instruction register, A, B and the output port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir     <= '0;
      reg_a  <= '0;
      reg_b  <= '0;
      outp_q <= '0;
    end else begin
      if ((state_q == S_FETCH) && imem_ack)
        ir <= imem_data;
      if (state_q == S_EXEC) begin
        case (dst_sel)
          DST_A:   reg_a  <= alu_sum;
          DST_B:   reg_b  <= alu_sum;
          DST_OUT: outp_q <= alu_sum;
          default: ;
        endcase
      end
    end
  end

  assign imem_addr  = pc;
  assign outp       = outp_q;
  assign out_strobe = out_strobe_q;
  assign carry      = carry_q;

endmodule
